// File: rtl/echo_delay_pkg.sv
// ---------------------------------------------------------------------------
// echo_delay_pkg
//   Shared types, constants and helpers for the echo_delay block.
//   - mode_e     : processing mode carried down the pipeline
//   - state_e    : sweep/run FSM encoding (also visible on the debug output)
//   - MIN_DELAY  : smallest delay the datapath supports without a bypass path
//   - decode_mode: maps the raw 2-bit mode input onto mode_e
//   - sat_add    : signed add with saturation to a given bit width
// ---------------------------------------------------------------------------
package echo_delay_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_DELAY  = 2'b01,
        MODE_ECHO   = 2'b10
    } mode_e;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // A delay of 1 would read the address that the previous sample is
    // writing on the same edge; 2 is the shortest hazard-free distance.
    localparam int MIN_DELAY = 2;

    // Encoding 11 is unused and behaves like the pure delay mode.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'b00:   return MODE_BYPASS;
            2'b10:   return MODE_ECHO;
            default: return MODE_DELAY;
        endcase
    endfunction

    // Adds two signed values and clamps the sum to the range of a signed
    // number of 'width' bits. Operands are already sign-extended to int.
    function automatic int sat_add(input int a, input int b, input int width);
        int sum;
        int hi;
        int lo;
        sum = a + b;
        hi  = (1 << (width - 1)) - 1;
        lo  = -hi - 1;
        if (sum > hi) begin
            return hi;
        end
        if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/echo_delay_if.sv
// ---------------------------------------------------------------------------
// echo_delay_if
//   Sample stream and control bundle of the echo_delay block.
//   Source side (master drives):
//     en        sample valid
//     din       signed input sample
//     delay     delay in accepted samples, captured with the sample
//     mode      00 bypass, 01 delay, 10 echo, 11 same as 01
//     fb_shift  echo feedback gain 2^-fb_shift
//     clr       single-cycle request to zero the delay buffer
//   Block side (slave drives):
//     ready       block can accept a sample
//     dout        signed output sample, holds between results
//     dout_valid  single-cycle pulse when dout carries a new result
//     dbg_state   current FSM state (ST_CLEAR / ST_RUN)
//
//   Handshake: a sample is transferred on every clock edge where en and
//   ready are both high. ready depends only on the FSM state, never on en,
//   so the source may hold en high across cycles to stream back-to-back.
// ---------------------------------------------------------------------------
interface echo_delay_if #(
    parameter int A_WIDTH = 9,
    parameter int D_WIDTH = 8
);

    logic                      en;
    logic signed [D_WIDTH-1:0] din;
    logic        [A_WIDTH-1:0] delay;
    logic        [1:0]         mode;
    logic        [2:0]         fb_shift;
    logic                      clr;

    logic                      ready;
    logic signed [D_WIDTH-1:0] dout;
    logic                      dout_valid;
    logic        [0:0]         dbg_state;

    modport master (
        output en, din, delay, mode, fb_shift, clr,
        input  ready, dout, dout_valid, dbg_state
    );

    modport slave (
        input  en, din, delay, mode, fb_shift, clr,
        output ready, dout, dout_valid, dbg_state
    );

endinterface

// File: rtl/echo_delay_ram.sv
// ---------------------------------------------------------------------------
// delay_ram
//   Simple dual-port sample store: one write port and one synchronous read
//   port on the same clock. The array carries no reset; the owning block
//   zeroes it with an explicit sweep.
//   Ports:
//     clk       clock
//     we_i      write enable
//     waddr_i   write address
//     wdata_i   write data
//     re_i      read enable
//     raddr_i   read address
//     rdata_o   read data, valid the cycle after re_i, held otherwise
// ---------------------------------------------------------------------------
module delay_ram #(
    parameter int A_WIDTH = 9,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [A_WIDTH-1:0] waddr_i,
    input  logic [D_WIDTH-1:0] wdata_i,
    input  logic               re_i,
    input  logic [A_WIDTH-1:0] raddr_i,
    output logic [D_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 2 ** A_WIDTH;

    logic [D_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/echo_delay.sv
// ---------------------------------------------------------------------------
// echo_delay
//   Circular-buffer delay line for signed audio samples with programmable
//   delay and three modes: bypass, pure delay and feedback echo. After reset
//   or a clr request the buffer is swept to zero, one address per cycle,
//   before samples are accepted again.
//   Ports:
//     clk   system clock
//     rst   asynchronous active-low reset
//     bus   echo_delay_if.slave: en/din/delay/mode/fb_shift/clr in,
//           ready/dout/dout_valid/dbg_state out
//   Pipeline:
//     stage 0 (accept): read buffer at wr_ptr - d_eff, capture the sample
//     stage 1          : combine sample with read data, write buffer
//     stage 2          : registered dout / dout_valid
// ---------------------------------------------------------------------------
module echo_delay
    import echo_delay_pkg::*;
#(
    parameter int A_WIDTH = 9,
    parameter int D_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    echo_delay_if.slave bus
);

    localparam int                 DEPTH     = 2 ** A_WIDTH;
    localparam logic [A_WIDTH-1:0] LAST_ADDR = A_WIDTH'(DEPTH - 1);
    localparam logic [A_WIDTH-1:0] MIN_D     = A_WIDTH'(MIN_DELAY);
    localparam logic [A_WIDTH-1:0] ONE       = A_WIDTH'(1);

    // FSM and pointers
    logic [0:0]         state_q, state_d;
    logic [A_WIDTH-1:0] clr_addr_q, clr_addr_d;
    logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic               sweep_we;

    // Stage 1 registers
    logic                      s1_valid_q;
    logic signed [D_WIDTH-1:0] s1_din_q;
    mode_e                     s1_mode_q;
    logic        [2:0]         s1_shift_q;
    logic        [A_WIDTH-1:0] s1_addr_q;

    // Stage 2 registers
    logic signed [D_WIDTH-1:0] dout_q;
    logic                      dout_valid_q;

    // Stage 0 signals
    logic               ready;
    logic               accept;
    logic [A_WIDTH-1:0] d_eff;
    logic [A_WIDTH-1:0] rd_addr;

    // Stage 1 datapath
    logic        [D_WIDTH-1:0] ram_rdata;
    logic signed [D_WIDTH-1:0] ram_q;
    logic signed [D_WIDTH-1:0] fb_term;
    logic signed [D_WIDTH-1:0] s1_out;
    logic signed [D_WIDTH-1:0] s1_wval;

    // RAM write port (shared by the stage-1 write and the clear sweep)
    logic               ram_we;
    logic [A_WIDTH-1:0] ram_waddr;
    logic [D_WIDTH-1:0] ram_wdata;

    // -----------------------------------------------------------------------
    // Stage 0: acceptance and read address
    // -----------------------------------------------------------------------
    assign ready   = (state_q == ST_RUN);
    assign accept  = bus.en && ready;
    assign d_eff   = (bus.delay < MIN_D) ? MIN_D : bus.delay;
    // Natural modulo-DEPTH wrap of the unsigned subtraction.
    assign rd_addr = wr_ptr_q - d_eff;

    // -----------------------------------------------------------------------
    // FSM: sweep the buffer to zero, then run
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        wr_ptr_d   = wr_ptr_q;
        sweep_we   = 1'b0;

        if (state_q == ST_RUN) begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + ONE;
            end
            if (bus.clr) begin
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
            end
        end else begin
            if (bus.clr) begin
                clr_addr_d = '0;
            end else if (!s1_valid_q) begin
                // A sample accepted on the clr cycle still owns the write
                // port for one cycle; the sweep waits for it.
                sweep_we = 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = ST_RUN;
                    wr_ptr_d   = '0;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + ONE;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: combine sample with delayed data
    // -----------------------------------------------------------------------
    assign ram_q   = ram_rdata;
    assign fb_term = ram_q >>> s1_shift_q;

    always_comb begin
        s1_out = ram_q;
        case (s1_mode_q)
            MODE_BYPASS: s1_out = s1_din_q;
            MODE_ECHO:   s1_out = D_WIDTH'(sat_add(int'(s1_din_q), int'(fb_term), D_WIDTH));
            default:     s1_out = ram_q;
        endcase
    end

    // Echo feeds its own output back into the buffer; the other modes store
    // the raw input so a later mode switch sees clean history.
    assign s1_wval   = (s1_mode_q == MODE_ECHO) ? s1_out : s1_din_q;

    assign ram_we    = s1_valid_q || sweep_we;
    assign ram_waddr = s1_valid_q ? s1_addr_q : clr_addr_q;
    assign ram_wdata = s1_valid_q ? s1_wval : '0;

    delay_ram #(
        .A_WIDTH (A_WIDTH),
        .D_WIDTH (D_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (accept),
        .raddr_i (rd_addr),
        .rdata_o (ram_rdata)
    );

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_CLEAR;
            clr_addr_q   <= '0;
            wr_ptr_q     <= '0;
            s1_valid_q   <= 1'b0;
            s1_din_q     <= '0;
            s1_mode_q    <= MODE_BYPASS;
            s1_shift_q   <= '0;
            s1_addr_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            wr_ptr_q     <= wr_ptr_d;
            s1_valid_q   <= accept;
            if (accept) begin
                s1_din_q   <= bus.din;
                s1_mode_q  <= decode_mode(bus.mode);
                s1_shift_q <= bus.fb_shift;
                s1_addr_q  <= wr_ptr_q;
            end
            dout_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                dout_q <= s1_out;
            end
        end
    end

    assign bus.ready      = ready;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: doc/echo_delay.md
Name: echo_delay

Overview:
- Parametrised successor to the single-channel signal-delay block: a circular-buffer delay line for signed audio samples with programmable delay, three modes (bypass, pure delay, feedback echo) and a self-clearing buffer.
- Sits between the mic-sample source and the DAC/output path.
- Samples arrive on a valid/ready strobe, not every clock.

Parameters:
- A_WIDTH, 9, address width; DEPTH = 2**A_WIDTH samples.
- D_WIDTH, 8, sample width, signed two's complement.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- en  input  1  sample valid; a sample is accepted when en && ready.
- din  input  D_WIDTH  signed input sample.
- delay  input  A_WIDTH  delay in accepted samples; sampled at acceptance.
- mode  input  2  00 bypass, 01 delay, 10 echo, 11 treated as 01.
- fb_shift  input  3  echo gain = 2^-fb_shift (arithmetic right shift).
- clr  input  1  one-cycle request to zero the buffer.
- ready  output  1  block can accept a sample.
- dout  output  D_WIDTH  signed output sample.
- dout_valid  output  1  dout holds a new result (one-cycle pulse).

Behaviour:
- Reset (rst low, async): FSM enters CLEAR; clear address 0; wr_ptr 0; ready 0; dout 0; dout_valid 0; pipeline valids 0.
- FSM CLEAR: one RAM write of 0 per cycle at addresses 0..DEPTH-1; ready 0; en ignored. After the write to DEPTH-1, go to RUN, wr_ptr 0.
- FSM RUN: ready 1.
- clr in RUN: go to CLEAR next cycle; ready drops the next cycle.
- clr in CLEAR: restarts the sweep at address 0.
- Samples already in the pipeline on a clr still complete. Their writes land before the sweep overwrites them.
- Effective delay: d_eff = max(delay, 2). 0 and 1 clamp to 2, which avoids a read-after-write hazard without a bypass path.
- Stage 0 (accept cycle): rd_addr = wr_ptr - d_eff mod DEPTH. Issue synchronous RAM read. Register din, mode, fb_shift and wr_ptr. Then wr_ptr += 1 mod DEPTH (natural wrap).
- Stage 1: RAM data q is available.
  - Bypass: out = din; write din.
  - Delay: out = q; write din.
  - Echo: s = din + (q >>> fb_shift) in D_WIDTH+1 bits, saturated to [-2^(D_WIDTH-1), 2^(D_WIDTH-1)-1]; out = s; write s (feedback).
  - The write goes to the stage-0 wr_ptr.
- Stage 2: dout <= out and dout_valid <= 1.
- Latency: exactly 2 cycles from acceptance to dout_valid. Throughput: 1 sample/cycle.
- dout holds its last value when no result is produced.
- Changing delay/mode/fb_shift between samples: takes effect on the next accepted sample; buffer contents are not modified.
- A RAM write in CLEAR and a stage-1 write cannot collide, because the FSM stalls entry to the sweep until stage 1 is empty.

Decomposition:
- Package echo_delay_pkg:
  - mode enum (MODE_BYPASS, MODE_DELAY, MODE_ECHO).
  - FSM state enum (ST_CLEAR, ST_RUN).
  - Constant MIN_DELAY = 2.
  - Saturation function sat_add.
- Sub-module delay_ram: simple dual-port, one write port and one synchronous read port, parametrised A_WIDTH/D_WIDTH, no reset on the array.

Test Plan (A_WIDTH=4, D_WIDTH=8, DEPTH=16):
- Reset, then idle: ready=0 for exactly 16 cycles, then 1; dout=0, dout_valid=0 throughout.
- mode=01, delay=3, feed impulse 100 then zeros back-to-back: dout_valid 2 cycles after each accept; output index 3 = 100, all other indices 0.
- mode=10, delay=4, fb_shift=1, impulse 64 then zeros: outputs at index 0=64, 4=32, 8=16, 12=8, 16=4; all others 0.
- mode=10, delay=2, fb_shift=0, constant input 100: index 0,1 = 100; index 2 onward = 127 (saturated). Constant -100 gives -128.
- delay=0 behaves as 2, and delay=15 with 40 samples gives correct wrap (output n = input n-15). Random en gaps give the same sequence.
- clr pulse mid-stream with delay=5: ready low 16 cycles. Next 5 outputs after resume are 0, then new inputs re-emerge. An async rst mid-stream gives the same outcome.
